// File: rtl/mem_access_unit.sv
// MEM-stage front end for a big-endian, word-organised data memory.
// Handles sub-word load extraction, read-modify-write sub-word stores and access faults.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] dm_read_data,
  output logic        dm_mem_read,
  output logic        dm_mem_write,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        fault
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;
  localparam logic [1:0]  SIZE_WORD = 2'b10;
  localparam logic [31:0] MAX_BASE  = 32'(MEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] base_q, base_d;

  logic [31:0] word_base;
  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        active;
  logic        bad;

  // Big-endian lanes: offset 0 is the most significant byte, so shift = (3 - offset) * 8.
  assign word_base  = {req_addr[31:2], 2'b00};
  assign byte_shift = {~req_addr[1:0], 3'b000};
  assign half_shift = {~req_addr[1], 4'b0000};
  assign lane_byte  = 8'(dm_read_data >> byte_shift);
  assign lane_half  = 16'(dm_read_data >> half_shift);
  assign active     = req_read | req_write;

  assign bad = (req_read && req_write)
            || (req_size == 2'b11)
            || (req_size == SIZE_HALF && req_addr[0])
            || (req_size == SIZE_WORD && req_addr[1:0] != 2'b00)
            || (word_base > MAX_BASE);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d       = state_q;
    merge_d       = merge_q;
    base_d        = base_q;
    dm_mem_read   = 1'b0;
    dm_mem_write  = 1'b0;
    dm_address    = word_base;
    dm_write_data = 32'h0;
    load_data     = 32'h0;
    stall         = 1'b0;
    fault         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (active) begin
          if (bad) begin
            fault = 1'b1;
          end else if (req_read) begin
            dm_mem_read = 1'b1;
            unique case (req_size)
              SIZE_BYTE: load_data = req_unsigned ? {24'h0, lane_byte}
                                                  : {{24{lane_byte[7]}}, lane_byte};
              SIZE_HALF: load_data = req_unsigned ? {16'h0, lane_half}
                                                  : {{16{lane_half[15]}}, lane_half};
              default:   load_data = dm_read_data;
            endcase
          end else if (req_size == SIZE_WORD) begin
            dm_mem_write  = 1'b1;
            dm_write_data = req_wdata;
          end else begin
            // Sub-word store: read the current word now, write the merged word next cycle.
            dm_mem_read = 1'b1;
            stall       = 1'b1;
            base_d      = word_base;
            state_d     = RMW_WR;
            if (req_size == SIZE_BYTE)
              merge_d = (dm_read_data & ~(32'h0000_00FF << byte_shift))
                      | (32'(req_wdata[7:0]) << byte_shift);
            else
              merge_d = (dm_read_data & ~(32'h0000_FFFF << half_shift))
                      | (32'(req_wdata[15:0]) << half_shift);
          end
        end
      end
      RMW_WR: begin
        dm_mem_write  = 1'b1;
        dm_address    = base_q;
        dm_write_data = merge_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output, which also drops a pending RMW write.
    if (reset) begin
      dm_mem_read   = 1'b0;
      dm_mem_write  = 1'b0;
      dm_address    = 32'h0;
      dm_write_data = 32'h0;
      load_data     = 32'h0;
      stall         = 1'b0;
      fault         = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      merge_q <= 32'h0;
      base_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single-cycle accesses and faults,
// plus hand sequences for read-modify-write stores, reset during RMW and back-to-back access.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] dm_read_data;
  logic        dm_mem_read, dm_mem_write, stall, fault;
  logic [31:0] dm_address, dm_write_data, load_data;

  logic        mem_clr;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_data;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .dm_read_data(dm_read_data),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_address(dm_address), .dm_write_data(dm_write_data),
    .load_data(load_data), .stall(stall), .fault(fault)
  );

  // Data memory model: combinational read, posedge write, plus a backdoor for preloading.
  assign dm_read_data = mem[dm_address[9:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else if (dm_mem_write) begin
      mem[dm_address[9:2]] <= dm_write_data;
    end
  end

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata;
    logic        exp_fault, exp_mrd, exp_mwr;
    logic [31:0] exp_load;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(string n, logic r, logic w, logic [1:0] s, logic u,
                              logic [31:0] a, logic [31:0] wd,
                              logic f, logic mr, logic mw, logic [31:0] ld);
    vec_t v;
    v.name = n; v.rd = r; v.wr = w; v.size = s; v.uns = u; v.addr = a; v.wdata = wd;
    v.exp_fault = f; v.exp_mrd = mr; v.exp_mwr = mw; v.exp_load = ld;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    req_read = r; req_write = w; req_size = s; req_unsigned = u; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] data);
    @(negedge clk);
    idle();
    bd_we = 1'b1; bd_idx = byte_addr[9:2]; bd_data = data;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // {fault, mem_read, mem_write, stall, load_data}
  function automatic logic [35:0] ctl(logic f, logic mr, logic mw, logic st, logic [31:0] ld);
    return {f, mr, mw, st, ld};
  endfunction

  logic [35:0] act_ctl;
  assign act_ctl = {fault, dm_mem_read, dm_mem_write, stall, load_data};

  initial begin
    reset = 1'b1; mem_clr = 1'b1; bd_we = 1'b0; bd_idx = 8'h0; bd_data = 32'h0;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check("reset_outputs", {act_ctl, dm_address[27:0]}, 64'h0);
    check("reset_wdata", {32'h0, dm_write_data}, 64'h0);
    @(negedge clk);
    mem_clr = 1'b0; reset = 1'b0;
    idle();

    poke(32'h10, 32'h8899_AABB);

    vecs[0]  = mk("LB_11",   1, 0, 2'b00, 0, 32'h11,  32'h0, 0, 1, 0, 32'hFFFF_FF99);
    vecs[1]  = mk("LBU_13",  1, 0, 2'b00, 1, 32'h13,  32'h0, 0, 1, 0, 32'h0000_00BB);
    vecs[2]  = mk("LH_12",   1, 0, 2'b01, 0, 32'h12,  32'h0, 0, 1, 0, 32'hFFFF_AABB);
    vecs[3]  = mk("LHU_10",  1, 0, 2'b01, 1, 32'h10,  32'h0, 0, 1, 0, 32'h0000_8899);
    vecs[4]  = mk("LW_10",   1, 0, 2'b10, 0, 32'h10,  32'h0, 0, 1, 0, 32'h8899_AABB);
    vecs[5]  = mk("LB_10",   1, 0, 2'b00, 0, 32'h10,  32'h0, 0, 1, 0, 32'hFFFF_FF88);
    vecs[6]  = mk("LBU_12",  1, 0, 2'b00, 1, 32'h12,  32'h0, 0, 1, 0, 32'h0000_00AA);
    vecs[7]  = mk("LHU_12",  1, 0, 2'b01, 1, 32'h12,  32'h0, 0, 1, 0, 32'h0000_AABB);
    vecs[8]  = mk("LH_10",   1, 0, 2'b01, 0, 32'h10,  32'h0, 0, 1, 0, 32'hFFFF_8899);
    vecs[9]  = mk("LW_3FC",  1, 0, 2'b10, 0, 32'h3FC, 32'h0, 0, 1, 0, 32'h0);
    vecs[10] = mk("LB_3FF",  1, 0, 2'b00, 0, 32'h3FF, 32'h0, 0, 1, 0, 32'h0);
    vecs[11] = mk("no_req",  0, 0, 2'b11, 0, 32'h7FF, 32'h0, 0, 0, 0, 32'h0);
    vecs[12] = mk("LW_06",   1, 0, 2'b10, 0, 32'h06,  32'h0, 1, 0, 0, 32'h0);
    vecs[13] = mk("LH_03",   1, 0, 2'b01, 0, 32'h03,  32'h0, 1, 0, 0, 32'h0);
    vecs[14] = mk("SW_3FE",  0, 1, 2'b10, 0, 32'h3FE, 32'h1234_5678, 1, 0, 0, 32'h0);
    vecs[15] = mk("LW_400",  1, 0, 2'b10, 0, 32'h400, 32'h0, 1, 0, 0, 32'h0);
    vecs[16] = mk("size_11", 1, 0, 2'b11, 0, 32'h10,  32'h0, 1, 0, 0, 32'h0);
    vecs[17] = mk("rd_wr",   1, 1, 2'b10, 0, 32'h10,  32'hCAFE_F00D, 1, 0, 0, 32'h0);
    vecs[18] = mk("LH_402",  1, 0, 2'b01, 0, 32'h402, 32'h0, 1, 0, 0, 32'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      #1;
      check(vecs[i].name, {28'h0, act_ctl},
            {28'h0, ctl(vecs[i].exp_fault, vecs[i].exp_mrd, vecs[i].exp_mwr, 1'b0, vecs[i].exp_load)});
    end
    @(negedge clk);
    idle();
    #1;
    check("fault_mem_3FC", {32'h0, mem[255]}, 64'h0);
    check("fault_mem_10", {32'h0, mem[4]}, {32'h0, 32'h8899_AABB});

    // SB 0x5A at 0x12; upper wdata bits must be ignored.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFF_FF5A);
    #1;
    check("sb_c0_ctl", {28'h0, act_ctl}, {28'h0, ctl(0, 1, 0, 1, 32'h0)});
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    #1;
    check("sb_c1_ctl", {28'h0, act_ctl}, {28'h0, ctl(0, 0, 1, 0, 32'h0)});
    check("sb_c1_addr_data", {dm_address, dm_write_data}, {32'h10, 32'h8899_5ABB});
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    #1;
    check("sb_readback", {28'h0, act_ctl}, {28'h0, ctl(0, 1, 0, 0, 32'h8899_5ABB)});

    // SH 0xCAFE at 0x12, then SW 0x14 with no stall, then SH at lane 0.
    poke(32'h10, 32'h1122_3344);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_CAFE);
    #1;
    check("sh_c0_stall", {60'h0, stall, dm_mem_read, dm_mem_write, fault}, {60'h0, 4'b1100});
    @(negedge clk);
    #1;
    check("sh_c1_addr_data", {dm_address, dm_write_data}, {32'h10, 32'h1122_CAFE});
    check("sh_c1_we", {62'h0, dm_mem_write, stall}, {62'h0, 2'b10});
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h5566_7788);
    #1;
    check("sw_after_sh", {28'h0, act_ctl}, {28'h0, ctl(0, 0, 1, 0, 32'h0)});
    check("sw_after_sh_data", {dm_address, dm_write_data}, {32'h14, 32'h5566_7788});
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_BEEF);
    #1;
    check("sh10_c0_stall", {63'h0, stall}, 64'h1);
    @(negedge clk);
    idle();
    #1;
    check("sh10_c1_data", {dm_address, dm_write_data}, {32'h10, 32'hBEEF_CAFE});
    @(negedge clk);
    #1;
    check("sh_mem_10", {32'h0, mem[4]}, {32'h0, 32'hBEEF_CAFE});
    check("sw_mem_14", {32'h0, mem[5]}, {32'h0, 32'h5566_7788});

    // Reset during the RMW_WR cycle drops the write.
    poke(32'h08, 32'hA1B2_C3D4);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h09, 32'h0000_0077);
    #1;
    check("rst_sb_c0_stall", {63'h0, stall}, 64'h1);
    @(negedge clk);
    reset = 1'b1;
    idle();
    #1;
    check("rst_rmw_ctl", {28'h0, act_ctl}, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_after_ctl", {28'h0, act_ctl}, 64'h0);
    check("rst_mem_08", {32'h0, mem[2]}, {32'h0, 32'hA1B2_C3D4});
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h08, 32'h0);
    #1;
    check("rst_idle_load", {28'h0, act_ctl}, {28'h0, ctl(0, 1, 0, 0, 32'hA1B2_C3D4)});

    // Back-to-back SW then LW.
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    #1;
    check("b2b_sw", {28'h0, act_ctl}, {28'h0, ctl(0, 0, 1, 0, 32'h0)});
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    #1;
    check("b2b_lw", {28'h0, act_ctl}, {28'h0, ctl(0, 1, 0, 0, 32'hDEAD_BEEF)});

    @(negedge clk);
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
